// File: rtl/mtx_sig_mc_if.sv
// Bus bundle for the multi-channel tone phase generator: configuration, frame control
// and the streaming output. The master drives stimulus; the slave is the generator.
interface mtx_sig_mc_if #(
   parameter int PHASE_WIDTH = 24,
   parameter int NSYMB_WIDTH = 16,
   parameter int NCHAN       = 4
);
   logic                         cfg_valid;
   logic [3:0]                   cfg_chan;
   logic [PHASE_WIDTH-1:0]       cfg_ph_start;
   logic [PHASE_WIDTH-1:0]       cfg_ph_step;
   logic [NSYMB_WIDTH-1:0]       symb_len;
   logic                         start;
   logic                         continuous;
   logic                         out_tready;
   logic                         out_tvalid;
   logic                         out_tlast;
   logic [NCHAN*PHASE_WIDTH-1:0] out_tdata;
   logic [NSYMB_WIDTH-1:0]       symbN;
   logic [NSYMB_WIDTH-1:0]       sampN;
   logic                         busy;

   modport master (
      output cfg_valid, cfg_chan, cfg_ph_start, cfg_ph_step, symb_len, start, continuous,
             out_tready,
      input  out_tvalid, out_tlast, out_tdata, symbN, sampN, busy
   );

   modport slave (
      input  cfg_valid, cfg_chan, cfg_ph_start, cfg_ph_step, symb_len, start, continuous,
             out_tready,
      output out_tvalid, out_tlast, out_tdata, symbN, sampN, busy
   );
endinterface

// File: rtl/mtx_sig_mc.sv
// Multi-channel frequency-hopping phase generator: each channel accumulates a phase whose
// increment steps once per symbol; frames stream out over a valid/ready handshake.
module mtx_sig_mc #(
   parameter int PHASE_WIDTH = 24,
   parameter int NSYMB_WIDTH = 16,
   parameter int NSYMB       = 64,
   parameter int NCHAN       = 4
) (
   input logic          clk_i,
   input logic          reset_i,
   input logic          srst_i,
   mtx_sig_mc_if.slave  bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [NSYMB_WIDTH-1:0] LAST_SYMB = NSYMB_WIDTH'(NSYMB - 1);

   state_t                              state_q, state_d;
   logic [NCHAN-1:0][PHASE_WIDTH-1:0]   acc_q, acc_d;
   logic [NCHAN-1:0][PHASE_WIDTH-1:0]   inc_q, inc_d;
   logic [NCHAN-1:0][PHASE_WIDTH-1:0]   ph_start_q, ph_start_d;
   logic [NCHAN-1:0][PHASE_WIDTH-1:0]   ph_step_q, ph_step_d;
   logic [NSYMB_WIDTH-1:0]              len_q, len_d;
   logic                                cont_q, cont_d;
   logic [NSYMB_WIDTH-1:0]              symb_q, symb_d;
   logic [NSYMB_WIDTH-1:0]              samp_q, samp_d;
   logic                                tlast_q, tlast_d;
   logic                                tvalid_q, tvalid_d;
   logic                                busy_q, busy_d;
   logic                                xfer_s;

   assign xfer_s = (state_q == ST_RUN) && bus.out_tready;

   // Next-state for control, counters and per-channel phase datapath.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      inc_d      = inc_q;
      ph_start_d = ph_start_q;
      ph_step_d  = ph_step_q;
      len_d      = len_q;
      cont_d     = cont_q;
      symb_d     = symb_q;
      samp_d     = samp_q;
      if (srst_i) begin
         state_d = ST_IDLE;
         acc_d   = '0;
         inc_d   = '0;
         len_d   = '0;
         cont_d  = 1'b0;
         symb_d  = '0;
         samp_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Out-of-range channel indices never match a loop index, so they are dropped.
               for (int c = 0; c < NCHAN; c++) begin
                  if (bus.cfg_valid && (4'(c) == bus.cfg_chan)) begin
                     ph_start_d[c] = bus.cfg_ph_start;
                     ph_step_d[c]  = bus.cfg_ph_step;
                  end else begin
                     ph_start_d[c] = ph_start_q[c];
                     ph_step_d[c]  = ph_step_q[c];
                  end
               end
               if (bus.start) begin
                  len_d   = (bus.symb_len == '0) ? NSYMB_WIDTH'(1) : bus.symb_len;
                  cont_d  = bus.continuous;
                  acc_d   = '0;
                  inc_d   = ph_start_q;
                  symb_d  = '0;
                  samp_d  = '0;
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (xfer_s) begin
                  for (int c = 0; c < NCHAN; c++) begin
                     acc_d[c] = acc_q[c] + inc_q[c];
                  end
                  if (tlast_q) begin
                     if (cont_q) begin
                        symb_d = '0;
                        samp_d = '0;
                        inc_d  = ph_start_q;
                     end else begin
                        state_d = ST_DONE;
                     end
                  end else if (samp_q == (len_q - NSYMB_WIDTH'(1))) begin
                     samp_d = '0;
                     symb_d = symb_q + NSYMB_WIDTH'(1);
                     for (int c = 0; c < NCHAN; c++) begin
                        inc_d[c] = inc_q[c] + ph_step_q[c];
                     end
                  end else begin
                     samp_d = samp_q + NSYMB_WIDTH'(1);
                  end
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
      // Flags are precomputed from next state so every output leaves a flop.
      tvalid_d = (state_d == ST_RUN);
      busy_d   = (state_d != ST_IDLE);
      tlast_d  = tvalid_d && (symb_d == LAST_SYMB) && (samp_d == (len_d - NSYMB_WIDTH'(1)));
   end

   // State, datapath and output registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         acc_q      <= '0;
         inc_q      <= '0;
         ph_start_q <= '0;
         ph_step_q  <= '0;
         len_q      <= '0;
         cont_q     <= 1'b0;
         symb_q     <= '0;
         samp_q     <= '0;
         tlast_q    <= 1'b0;
         tvalid_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         inc_q      <= inc_d;
         ph_start_q <= ph_start_d;
         ph_step_q  <= ph_step_d;
         len_q      <= len_d;
         cont_q     <= cont_d;
         symb_q     <= symb_d;
         samp_q     <= samp_d;
         tlast_q    <= tlast_d;
         tvalid_q   <= tvalid_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.out_tvalid = tvalid_q;
   assign bus.out_tlast  = tlast_q;
   assign bus.out_tdata  = acc_q;
   assign bus.symbN      = symb_q;
   assign bus.sampN      = samp_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mtx_sig_mc.sv
// Bench for mtx_sig_mc (NCHAN=2, NSYMB=2): directed scenarios plus randomized frames
// compared against an arithmetic phase model.
module tb_mtx_sig_mc;
   localparam int PW    = 24;
   localparam int SW    = 16;
   localparam int NSYMB = 2;
   localparam int NCHAN = 2;

   logic clk = 1'b0;
   logic reset, srst;
   int   total = 0;
   int   bad   = 0;
   logic [PW-1:0] mstart [NCHAN];
   logic [PW-1:0] mstep  [NCHAN];

   always #5 clk = ~clk;

   mtx_sig_mc_if #(.PHASE_WIDTH(PW), .NSYMB_WIDTH(SW), .NCHAN(NCHAN)) bus ();

   mtx_sig_mc #(.PHASE_WIDTH(PW), .NSYMB_WIDTH(SW), .NSYMB(NSYMB), .NCHAN(NCHAN)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .srst_i  (srst),
      .bus     (bus.slave)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Phase of channel c at global sample k: sum of the increments of all earlier samples.
   function automatic logic [PW-1:0] mphase(input int c, input int k, input int len);
      logic [PW-1:0] p = '0;
      int fl = NSYMB * len;
      for (int m = 0; m < k; m++) p = p + mstart[c] + mstep[c] * PW'((m % fl) / len);
      return p;
   endfunction

   task automatic cfg_write(input int ch, input logic [PW-1:0] st, input logic [PW-1:0] sp);
      @(negedge clk);
      bus.cfg_valid = 1'b1; bus.cfg_chan = 4'(ch); bus.cfg_ph_start = st; bus.cfg_ph_step = sp;
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      if (ch < NCHAN) begin mstart[ch] = st; mstep[ch] = sp; end
   endtask

   task automatic do_start(input int len, input bit cont);
      @(negedge clk);
      bus.start = 1'b1; bus.symb_len = SW'(len); bus.continuous = cont;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Collect n transfers; mode 0 ready always, 1 toggling, 2 random. inj = cycle of a stray cfg write.
   task automatic collect(input int n, input int mode, input int len, input int inj);
      int got = 0;
      int cyc = 0;
      int fl = NSYMB * len;
      bit stalled = 1'b0;
      logic [NCHAN*PW-1:0] sd;
      logic [2*SW:0] sidx;
      while (got < n && cyc < 4 * n + 20) begin
         @(negedge clk);
         cyc++;
         check("tvalid_run", 64'(bus.out_tvalid), 64'd1);
         if (stalled) begin
            check("stall_data", 64'(bus.out_tdata), 64'(sd));
            check("stall_idx", 64'({bus.symbN, bus.sampN, bus.out_tlast}), 64'(sidx));
         end
         bus.cfg_valid = (cyc == inj); bus.cfg_chan = 4'd0;
         bus.cfg_ph_start = PW'($urandom); bus.cfg_ph_step = PW'($urandom);
         case (mode)
            0:       bus.out_tready = 1'b1;
            1:       bus.out_tready = ((cyc % 2) == 1);
            default: bus.out_tready = 1'($urandom_range(0, 1));
         endcase
         if (bus.out_tready) begin
            for (int c = 0; c < NCHAN; c++)
               check($sformatf("ch%0d_phase_k%0d", c, got), 64'(bus.out_tdata[c*PW +: PW]),
                     64'(mphase(c, got, len)));
            check("symbN", 64'(bus.symbN), 64'((got % fl) / len));
            check("sampN", 64'(bus.sampN), 64'(got % len));
            check("tlast", 64'(bus.out_tlast), 64'((got % fl) == fl - 1));
            got++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            sd = bus.out_tdata;
            sidx = {bus.symbN, bus.sampN, bus.out_tlast};
         end
      end
      bus.cfg_valid = 1'b0;
      check("xfer_count", 64'(got), 64'(n));
   endtask

   task automatic finish_oneshot();
      @(negedge clk);
      check("done_tvalid", 64'(bus.out_tvalid), 64'd0);
      check("done_busy", 64'(bus.busy), 64'd1);
      @(negedge clk);
      check("idle_busy", 64'(bus.busy), 64'd0);
   endtask

   task automatic do_srst(input bit with_start);
      @(negedge clk);
      srst = 1'b1; bus.start = with_start; bus.symb_len = SW'(1); bus.continuous = 1'b0;
      @(posedge clk); #1;
      srst = 1'b0; bus.start = 1'b0;
      @(negedge clk);
      check("srst_tvalid", 64'(bus.out_tvalid), 64'd0);
      check("srst_busy", 64'(bus.busy), 64'd0);
      check("srst_cnt", 64'({bus.symbN, bus.sampN}), 64'd0);
      check("srst_data", 64'(bus.out_tdata), 64'd0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_tvalid"}, 64'(bus.out_tvalid), 64'd0);
      check({tag, "_tlast"}, 64'(bus.out_tlast), 64'd0);
      check({tag, "_tdata"}, 64'(bus.out_tdata), 64'd0);
      check({tag, "_cnt"}, 64'({bus.symbN, bus.sampN}), 64'd0);
      check({tag, "_busy"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int len, elen;
      bit cont;
      reset = 1'b1; srst = 1'b0;
      bus.cfg_valid = 1'b0; bus.cfg_chan = 4'd0; bus.cfg_ph_start = '0; bus.cfg_ph_step = '0;
      bus.symb_len = '0; bus.start = 1'b0; bus.continuous = 1'b0; bus.out_tready = 1'b0;
      for (int c = 0; c < NCHAN; c++) begin mstart[c] = '0; mstep[c] = '0; end
      repeat (3) @(negedge clk);
      check_zero_outputs("in_reset");
      reset = 1'b0;
      @(negedge clk);
      check_zero_outputs("after_reset");

      // Two-symbol frame, ready held high, then toggling ready.
      cfg_write(0, 24'h000100, 24'h000010);
      cfg_write(1, 24'h000200, 24'h000000);
      do_start(2, 1'b0); collect(4, 0, 2, 0); finish_oneshot();
      do_start(2, 1'b0); collect(4, 1, 2, 0); finish_oneshot();

      // Continuous frames with wrap-around phases.
      cfg_write(0, 24'h800000, 24'h000000);
      do_start(1, 1'b1); collect(6, 0, 1, 0); do_srst(1'b0);

      // Stray writes: out-of-range channel and during RUN; symb_len 0 acts as 1.
      cfg_write(2, 24'h123456, 24'h654321);
      do_start(0, 1'b0); collect(2, 0, 1, 1); finish_oneshot();

      // Soft restart together with start mid-frame, then rerun with retained config.
      cfg_write(0, 24'h000100, 24'h000010);
      do_start(3, 1'b0); collect(3, 0, 3, 0); do_srst(1'b1);
      do_start(3, 1'b0); collect(6, 2, 3, 0); finish_oneshot();

      for (int it = 0; it < 6; it++) begin
         for (int c = 0; c < NCHAN; c++) cfg_write(c, PW'($urandom), PW'($urandom));
         len  = $urandom_range(0, 3);
         elen = (len == 0) ? 1 : len;
         cont = 1'($urandom_range(0, 1));
         do_start(len, cont);
         if (cont) begin
            collect(2 * NSYMB * elen + 1, 2, elen, 0); do_srst(1'b0);
         end else begin
            collect(NSYMB * elen, 2, elen, 2); finish_oneshot();
         end
      end

      // Hard reset mid-frame clears config; a new frame then carries zero phases.
      do_start(2, 1'b0); collect(2, 0, 2, 0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      for (int c = 0; c < NCHAN; c++) begin mstart[c] = '0; mstep[c] = '0; end
      @(negedge clk); check_zero_outputs("reset_mid");
      @(negedge clk); check("reset_hold_tvalid", 64'(bus.out_tvalid), 64'd0);
      do_start(2, 1'b0); collect(4, 0, 2, 0); finish_oneshot();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mtx_sig_mc.md
MTX_SIG_MC -- requirements
Module: mtx_sig_mc

Interface
REQ-001 Parameter PHASE_WIDTH, default 24, width of phase accumulators, increments and output phases.
REQ-002 Parameter NSYMB_WIDTH, default 16, width of symbol and sample counters.
REQ-003 Parameter NSYMB, default 64, symbols per frame; legal range 1..2^NSYMB_WIDTH.
REQ-004 Parameter NCHAN, default 4, number of independent tone channels; legal range 1..16.
REQ-005 Port clk  input  1  sole clock; all logic on rising edge.
REQ-006 Port reset  input  1  synchronous, active-high; clears all state including configuration.
REQ-007 Port srst  input  1  synchronous, active-high soft restart; clears run state, keeps configuration.
REQ-008 Port cfg_valid  input  1  configuration write strobe.
REQ-009 Port cfg_chan  input  4  channel index of the configuration write.
REQ-010 Port cfg_ph_start  input  PHASE_WIDTH  channel base phase increment (symbol 0 frequency).
REQ-011 Port cfg_ph_step  input  PHASE_WIDTH  channel per-symbol increment step (frequency hop).
REQ-012 Port symb_len  input  NSYMB_WIDTH  samples per symbol; sampled at start.
REQ-013 Port start  input  1  single-cycle frame start request.
REQ-014 Port continuous  input  1  1 = repeat frames; 0 = stop after one frame; sampled at start.
REQ-015 Port out_tready  input  1  downstream ready.
REQ-016 Port out_tvalid  output  1  output sample valid.
REQ-017 Port out_tlast  output  1  last sample of frame.
REQ-018 Port out_tdata  output  NCHAN*PHASE_WIDTH  channel c phase at bits [c*PHASE_WIDTH +: PHASE_WIDTH].
REQ-019 Port symbN  output  NSYMB_WIDTH  symbol index of the current out_tdata.
REQ-020 Port sampN  output  NSYMB_WIDTH  sample index within symbol of the current out_tdata.
REQ-021 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-022 States: IDLE, RUN, DONE; DONE returns to IDLE in the next cycle.
REQ-023 cfg_valid in IDLE with cfg_chan<NCHAN writes ph_start[cfg_chan] and ph_step[cfg_chan]; in other states or with cfg_chan>=NCHAN the write is ignored.
REQ-024 start in IDLE: latch symb_len (0 treated as 1) and continuous; set acc[c]=0, inc[c]=ph_start[c], symbN=0, sampN=0; enter RUN; start outside IDLE is ignored.
REQ-025 out_tvalid is 1 in every RUN cycle, starting the cycle after start; 0 in IDLE and DONE.
REQ-026 out_tdata[c]=acc[c]; the first sample of a frame is all-zero phases.
REQ-027 Transfer = out_tvalid & out_tready; out_tdata, symbN, sampN, out_tlast stay constant while out_tvalid & !out_tready.
REQ-028 On transfer: acc[c] <= acc[c]+inc[c] modulo 2^PHASE_WIDTH (wrap, no saturation); sampN increments.
REQ-029 On transfer with sampN==symb_len-1: sampN<=0, symbN increments, inc[c]<=inc[c]+ph_step[c] modulo 2^PHASE_WIDTH.
REQ-030 out_tlast = RUN & symbN==NSYMB-1 & sampN==symb_len-1.
REQ-031 Transfer with out_tlast and continuous=1: symbN<=0, sampN<=0, inc[c]<=ph_start[c], acc continues accumulating (phase continuous); state stays RUN.
REQ-032 Transfer with out_tlast and continuous=0: enter DONE; acc, counters hold last-updated values.
REQ-033 Frame length in samples is exactly NSYMB*symb_len transfers; NSYMB=1 and symb_len=1 give out_tlast on every sample.
REQ-034 srst in any state: enter IDLE, out_tvalid=0, acc, inc, symbN, sampN cleared; ph_start/ph_step retained.
REQ-035 srst has priority over start, cfg_valid and transfer in the same cycle; reset has priority over srst.
REQ-036 No combinational path from out_tready to out_tvalid or out_tdata.

Reset
REQ-037 While reset is high and on the following cycle: out_tvalid=0, out_tlast=0, out_tdata=0, symbN=0, sampN=0, busy=0, state IDLE, all ph_start/ph_step=0.
REQ-038 reset mid-frame aborts the frame with no further transfers; a new start is required.

Verification
REQ-039 NCHAN=2, ph_start={0x000100,0x000200}, step={0x10,0}, symb_len=2, NSYMB=2, tready=1, oneshot -> ch0 phases 0,0x100,0x200,0x310; tlast on sample 4; busy drops 2 cycles later.
REQ-040 Same config, tready toggling 1/0 each cycle -> identical 4-sample sequence, data and tlast stable during stalls.
REQ-041 continuous=1, NSYMB=2, symb_len=1, ph_start=0x800000, step=0 -> phases 0,0x800000,0,0x800000 (wrap) with tlast every 2nd sample, no gap between frames.
REQ-042 srst asserted mid-frame together with start -> IDLE next cycle, out_tvalid=0, counters 0; subsequent start reproduces first-frame phases using retained config.
REQ-043 cfg_valid during RUN and with cfg_chan=NCHAN -> no change to generated phases; symb_len=0 -> behaves as 1.
